// File: rtl/pipeline_register_if.sv
// Valid/ready/data handshake bundle shared by both sides of pipeline_register.
// The master drives valid and data and samples ready; the slave does the reverse.
interface pipeline_register_if #(
   parameter int WORD_LENGTH = 8
) ();

   logic                   valid;
   logic                   ready;
   logic [WORD_LENGTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface : pipeline_register_if

// File: rtl/pipeline_register.sv
// Elastic DEPTH-stage data pipeline with valid/ready on both sides.
// Empty stages keep advancing under back-pressure, so bubbles collapse and the
// upstream side only stalls once every stage holds a word. A synchronous flush
// drops all words in flight. A registered occupancy count tracks the number of
// valid stages.
module pipeline_register #(
   parameter int WORD_LENGTH = 8,
   parameter int DEPTH       = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   pipeline_register_if.slave           in_bus,
   pipeline_register_if.master          out_bus,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   // Number of set bits in a stage-valid vector.
   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
      logic [OCC_W-1:0] cnt;
      cnt = {OCC_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         cnt = cnt + OCC_W'(vec[k]);
      end
      return cnt;
   endfunction

   // Stage state: bit/entry 0 is the stage nearest the input.
   logic [DEPTH-1:0]       valid_r;
   logic [WORD_LENGTH-1:0] data_r [DEPTH];
   logic [OCC_W-1:0]       occupancy_r;

   // Combinational next state and ready chain.
   logic [DEPTH-1:0]       rdy_s;
   logic [DEPTH:0]         chain_valid_s;
   logic [WORD_LENGTH-1:0] chain_data_s [DEPTH+1];
   logic [DEPTH-1:0]       valid_nxt_s;
   logic [WORD_LENGTH-1:0] data_nxt_s [DEPTH];

   // Ready chain from the output back to stage 0: a stage can take a word when it
   // is empty or when the stage ahead of it can take its word.
   always_comb begin
      logic rdy_v;
      rdy_v = out_bus.ready;
      rdy_s = {DEPTH{1'b0}};
      for (int k = DEPTH - 1; k >= 0; k--) begin
         rdy_v    = ~valid_r[k] | rdy_v;
         rdy_s[k] = rdy_v;
      end
   end

   // View of each stage's upstream neighbour; position 0 is the input port.
   always_comb begin
      chain_valid_s   = {valid_r, in_bus.valid};
      chain_data_s[0] = in_bus.data;
      for (int k = 0; k < DEPTH; k++) begin
         chain_data_s[k+1] = data_r[k];
      end
   end

   // Next stage contents: a ready stage takes its neighbour's valid bit and, only
   // when that neighbour is valid, its data. Flush clears every valid bit but
   // leaves the data untouched. Data never loads from an invalid source, so an
   // undriven in_data cannot leak into valid or occupancy.
   always_comb begin
      valid_nxt_s = valid_r;
      for (int k = 0; k < DEPTH; k++) begin
         data_nxt_s[k] = data_r[k];
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (flush) begin
            valid_nxt_s[k] = 1'b0;
         end else if (rdy_s[k]) begin
            valid_nxt_s[k] = chain_valid_s[k];
            if (chain_valid_s[k]) begin
               data_nxt_s[k] = chain_data_s[k];
            end else begin
               data_nxt_s[k] = data_r[k];
            end
         end else begin
            valid_nxt_s[k] = valid_r[k];
         end
      end
   end

   // Stage valid bits and the occupancy count, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r     <= {DEPTH{1'b0}};
         occupancy_r <= {OCC_W{1'b0}};
      end else begin
         valid_r     <= valid_nxt_s;
         occupancy_r <= popcount(valid_nxt_s);
      end
   end

   // Stage data registers, cleared to zero asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_r[k] <= {WORD_LENGTH{1'b0}};
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            data_r[k] <= data_nxt_s[k];
         end
      end
   end

   // Outputs: the last stage drives the downstream side straight from its flops.
   assign out_bus.valid = valid_r[DEPTH-1];
   assign out_bus.data  = data_r[DEPTH-1];
   assign in_bus.ready  = rdy_s[0];
   assign occupancy     = occupancy_r;

endmodule : pipeline_register

// File: tb/tb_pipeline_register.sv
// Directed, table-driven bench for pipeline_register (DEPTH=3, WORD_LENGTH=8).
// Each table row gives the inputs held for one clock cycle and the outputs
// expected during that same cycle; a few hand-written sequences cover reset.
module tb_pipeline_register;

   localparam int WL = 8;
   localparam int DP = 3;
   localparam int OW = $clog2(DP + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic [OW-1:0] occupancy;

   pipeline_register_if #(.WORD_LENGTH(WL)) in_if ();
   pipeline_register_if #(.WORD_LENGTH(WL)) out_if ();

   pipeline_register #(
      .WORD_LENGTH (WL),
      .DEPTH       (DP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_bus    (in_if),
      .out_bus   (out_if),
      .occupancy (occupancy)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [WL-1:0] id;
      logic          ordy;
      logic          fl;
      logic          eov;
      logic [WL-1:0] eod;
      logic          eir;
      logic [OW-1:0] eocc;
   } vec_t;

   vec_t tbl [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [WL-1:0] id, input logic ordy,
                      input logic fl, input logic eov, input logic [WL-1:0] eod,
                      input logic eir, input logic [OW-1:0] eocc);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc;
      tbl.push_back(v);
   endtask

   // Back-to-back stream with out_ready=1: n words base, base+1, ... offered in
   // cycles 0..n-1, table covers cycles 0..ncyc-1. Word j is at the output in
   // cycle j+3; the stages hold the words offered in cycles c-1, c-2, c-3.
   // in_data is driven to X while in_valid is low.
   task automatic fill_stream(input int n, input logic [WL-1:0] base, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         logic          iv;
         logic [WL-1:0] id;
         logic          ov;
         logic [WL-1:0] od;
         int            cnt;
         iv  = (c < n);
         id  = iv ? WL'(base + c) : {WL{1'bx}};
         ov  = (c >= 3) && (c - 3 < n);
         od  = ov ? WL'(base + c - 3) : {WL{1'b0}};
         cnt = 0;
         for (int k = 1; k <= 3; k++) begin
            if ((c - k >= 0) && (c - k < n)) cnt++;
         end
         add(iv, id, 1'b1, 1'b0, ov, od, 1'b1, OW'(cnt));
      end
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i < last; i++) begin
         @(posedge clk);
         #1;
         in_if.valid  = tbl[i].iv;
         in_if.data   = tbl[i].id;
         out_if.ready = tbl[i].ordy;
         flush        = tbl[i].fl;
         @(negedge clk);
         check("out_valid", i, 32'(out_if.valid), 32'(tbl[i].eov));
         if (tbl[i].eov) check("out_data", i, 32'(out_if.data), 32'(tbl[i].eod));
         check("in_ready", i, 32'(in_if.ready), 32'(tbl[i].eir));
         check("occupancy", i, 32'(occupancy), 32'(tbl[i].eocc));
      end
   endtask

   initial begin
      int g2, g3, g4, g5, g6a, g6b;

      reset        = 1'b0;
      flush        = 1'b0;
      in_if.valid  = 1'b0;
      in_if.data   = 8'h00;
      out_if.ready = 1'b0;

      // Reset state, sampled while reset is held low.
      #12;
      check("rst_out_valid", -1, 32'(out_if.valid), 32'd0);
      check("rst_out_data", -1, 32'(out_if.data), 32'h00);
      check("rst_occupancy", -1, 32'(occupancy), 32'd0);
      check("rst_in_ready", -1, 32'(in_if.ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // Stream 0x01..0x0A at full rate, drained by three idle cycles.
      g2 = tbl.size();
      fill_stream(10, 8'h01, 13);

      // Full back-pressure: 0x44 held until out_ready rises.
      g3 = tbl.size();
      add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);
      add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1);
      add(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2);
      add(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2'd3);
      add(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2'd3);
      add(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 2'd3);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 2'd3);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 2'd2);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 2'd1);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);

      // Bubble collapse: 0xA1 and 0xA2 settle in stages 2 and 1 under stall.
      g4 = tbl.size();
      add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1);
      add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd1);
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);

      // Flush at occupancy 2 with 0x55 offered: pipeline empties, 0x55 never shows.
      g5 = tbl.size();
      add(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);
      add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1);
      add(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2);
      for (int i = 0; i < 4; i++) begin
         add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0);
      end

      // Stream interrupted by reset, then a fresh stream after release.
      g6a = tbl.size();
      fill_stream(6, 8'h61, 4);
      g6b = tbl.size();
      fill_stream(4, 8'h71, 8);

      run_rows(g2, g3);
      run_rows(g3, g4);
      run_rows(g4, g5);
      run_rows(g5, g6a);
      run_rows(g6a, g6b);

      // Mid-cycle asynchronous reset with three words in flight.
      @(posedge clk);
      #1;
      in_if.valid = 1'b1;
      in_if.data  = 8'h65;
      #2;
      check("pre_rst_out_data", -2, 32'(out_if.data), 32'h62);
      check("pre_rst_occupancy", -2, 32'(occupancy), 32'd3);
      reset = 1'b0;
      #1;
      check("async_out_valid", -2, 32'(out_if.valid), 32'd0);
      check("async_out_data", -2, 32'(out_if.data), 32'h00);
      check("async_occupancy", -2, 32'(occupancy), 32'd0);
      check("async_in_ready", -2, 32'(in_if.ready), 32'd1);
      @(negedge clk);
      in_if.valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("held_rst_out_valid", -3, 32'(out_if.valid), 32'd0);
      reset = 1'b1;

      run_rows(g6b, tbl.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipeline_register
